// File: rtl/traffic_pkg.sv
// Shared traffic-state encodings and widths for the traffic-light FSM and its
// timing/input stage.
package traffic_pkg;

  localparam int TRAFF_W = 3;

  typedef enum logic [TRAFF_W-1:0] {
    ST_IDLE      = 3'b000,
    ST_NS_GREEN  = 3'b001,
    ST_NS_YELLOW = 3'b010,
    ST_EW_GREEN  = 3'b011,
    ST_PED_WALK  = 3'b100,
    ST_EW_YELLOW = 3'b101
  } traff_state_e;

  localparam logic [TRAFF_W-1:0] PED_SERVE_DEFAULT = ST_PED_WALK;

endpackage

// File: rtl/traffic_timer_ctrl_button_debounce.sv
// Pedestrian button: 2-flop synchroniser, consecutive-sample debounce and a
// one-cycle pulse on each rising edge of the accepted level.
module button_debounce #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk_out,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   stable_reg;
  logic                   stable_d_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      sync_reg     <= '0;
      cnt_reg      <= '0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], button};
      stable_d_reg <= stable_reg;
      // cnt_reg holds how many differing samples have already been seen in a row
      if (synced == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
        stable_reg <= synced;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/traffic_timer_ctrl.sv
// Per-state elapsed-time flags and latched pedestrian request feeding the
// traffic-light FSM; both timers restart whenever the reported state changes.
module traffic_timer_ctrl
  import traffic_pkg::*;
#(
  parameter int                 TICKS_PER_SEC   = 100,
  parameter int                 LONG_SEC        = 30,
  parameter int                 SHORT_SEC       = 3,
  parameter int                 DEBOUNCE_CYC    = 4,
  parameter logic [TRAFF_W-1:0] PED_SERVE_STATE = PED_SERVE_DEFAULT
) (
  input  logic               clk_out,
  input  logic               reset,
  input  logic [TRAFF_W-1:0] traff_state,
  input  logic               button,
  output logic               timer_30s,
  output logic               timer_3s,
  output logic               ped_req,
  output logic [5:0]         sec_count
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [TRAFF_W-1:0] state_q;
  logic [PW-1:0]      prescaler_reg;
  logic [5:0]         sec_count_reg;
  logic               chg;
  logic               terminal;
  logic               sec_tick;
  logic               press;

  assign chg      = (traff_state != state_q);
  assign terminal = (prescaler_reg == PW'(TICKS_PER_SEC - 1));
  assign sec_tick = terminal && !chg;

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q       <= '0;
      prescaler_reg <= '0;
      sec_count_reg <= '0;
      timer_3s      <= 1'b0;
      timer_30s     <= 1'b0;
    end else begin
      state_q <= traff_state;
      if (chg || terminal) prescaler_reg <= '0;
      else                 prescaler_reg <= prescaler_reg + 1'b1;
      // chg outranks a coincident sec_tick so a fresh state always starts at 0
      if (chg)
        sec_count_reg <= '0;
      else if (sec_tick && (sec_count_reg < 6'(LONG_SEC)))
        sec_count_reg <= sec_count_reg + 6'd1;
      if (chg) begin
        timer_3s  <= 1'b0;
        timer_30s <= 1'b0;
      end else begin
        timer_3s  <= (sec_count_reg >= 6'(SHORT_SEC));
        timer_30s <= (sec_count_reg >= 6'(LONG_SEC));
      end
    end
  end

  button_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .SYNC_STAGES  (2)
  ) u_debounce (
    .clk_out (clk_out),
    .reset   (reset),
    .button  (button),
    .press   (press)
  );

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset)                               ped_req <= 1'b0;
    else if (traff_state == PED_SERVE_STATE) ped_req <= 1'b0;
    else if (press)                          ped_req <= 1'b1;
  end

  assign sec_count = sec_count_reg;

endmodule

// File: tb/tb_traffic_timer_ctrl.sv
// Directed bench for traffic_timer_ctrl with short timing parameters.
module tb_traffic_timer_ctrl;

  logic       clk_out = 1'b0;
  logic       reset   = 1'b1;
  logic [2:0] traff_state = 3'b001;
  logic       button  = 1'b0;
  logic       timer_30s, timer_3s, ped_req;
  logic [5:0] sec_count;

  int n_vec = 0;
  int n_err = 0;

  traffic_timer_ctrl #(
    .TICKS_PER_SEC   (4),
    .LONG_SEC        (5),
    .SHORT_SEC       (2),
    .DEBOUNCE_CYC    (3),
    .PED_SERVE_STATE (3'b100)
  ) dut (
    .clk_out     (clk_out),
    .reset       (reset),
    .traff_state (traff_state),
    .button      (button),
    .timer_30s   (timer_30s),
    .timer_3s    (timer_3s),
    .ped_req     (ped_req),
    .sec_count   (sec_count)
  );

  always #5 clk_out = ~clk_out;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_out);
      #1;
    end
  endtask

  // Expected timing after the k-th edge following a state change (edge 0 = change):
  // sec_count ticks every 4 edges, saturating at 5; timer_3s rises at edge 9, timer_30s at edge 21.
  task automatic check_timing(input string tag, input int k, input logic check_long);
    logic [5:0] exp_sec;
    exp_sec = 6'((k / 4 > 5) ? 5 : k / 4);
    n_vec++;
    if (sec_count !== exp_sec) begin
      n_err++;
      $display("FAIL %s sec_count k=%0d got=%0d exp=%0d", tag, k, sec_count, exp_sec);
    end
    n_vec++;
    if (timer_3s !== (k >= 9)) begin
      n_err++;
      $display("FAIL %s timer_3s k=%0d got=%0b exp=%0b", tag, k, timer_3s, (k >= 9));
    end
    n_vec++;
    if (timer_30s !== (check_long && k >= 21)) begin
      n_err++;
      $display("FAIL %s timer_30s k=%0d got=%0b exp=%0b", tag, k, timer_30s, (check_long && k >= 21));
    end
  endtask

  task automatic test_reset;
    step(3);
    n_vec++;
    if ({timer_30s, timer_3s, ped_req, sec_count} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_state got=%b exp=%b", {timer_30s, timer_3s, ped_req, sec_count}, 9'd0);
    end
    $display("reset: outputs t30=%0b t3=%0b ped=%0b sec=%0d", timer_30s, timer_3s, ped_req, sec_count);
  endtask

  task automatic test_long_timer;
    reset = 1'b0;
    for (int k = 0; k <= 25; k++) begin
      step(1);
      check_timing("long_timer", k, 1'b1);
    end
    $display("long_timer: state 001 held, sec=%0d t3=%0b t30=%0b", sec_count, timer_3s, timer_30s);
  endtask

  task automatic test_state_change;
    traff_state = 3'b010;
    for (int k = 0; k <= 12; k++) begin
      step(1);
      check_timing("state_change", k, 1'b1);
    end
    $display("state_change: 001->010, sec=%0d t3=%0b", sec_count, timer_3s);
  endtask

  task automatic test_tick_collision;
    step(3);
    n_vec++;
    if (sec_count !== 6'd3) begin
      n_err++;
      $display("FAIL collision_pre sec_count got=%0d exp=3", sec_count);
    end
    traff_state = 3'b011;
    step(1);
    n_vec++;
    if (sec_count !== 6'd0) begin
      n_err++;
      $display("FAIL collision_chg sec_count got=%0d exp=0", sec_count);
    end
    step(3);
    n_vec++;
    if (sec_count !== 6'd0) begin
      n_err++;
      $display("FAIL collision_restart3 sec_count got=%0d exp=0", sec_count);
    end
    step(1);
    n_vec++;
    if (sec_count !== 6'd1) begin
      n_err++;
      $display("FAIL collision_restart4 sec_count got=%0d exp=1", sec_count);
    end
    $display("tick_collision: change on sec_tick, sec=%0d", sec_count);
  endtask

  task automatic test_glitch(input int width);
    button = 1'b1;
    step(width);
    button = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      n_vec++;
      if (ped_req !== 1'b0) begin
        n_err++;
        $display("FAIL glitch%0d ped_req k=%0d got=%0b exp=0", width, k, ped_req);
      end
    end
    $display("glitch: %0d-cycle pulse, ped_req=%0b", width, ped_req);
  endtask

  task automatic test_button_press;
    button = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      n_vec++;
      if (ped_req !== (k == 6)) begin
        n_err++;
        $display("FAIL press_latency ped_req k=%0d got=%0b exp=%0b", k, ped_req, (k == 6));
      end
    end
    button = 1'b0;
    step(8);
    n_vec++;
    if (ped_req !== 1'b1) begin
      n_err++;
      $display("FAIL press_hold ped_req got=%0b exp=1", ped_req);
    end
    $display("button_press: ped_req=%0b", ped_req);
  endtask

  task automatic test_ped_clear;
    traff_state = 3'b100;
    step(1);
    n_vec++;
    if (ped_req !== 1'b0) begin
      n_err++;
      $display("FAIL ped_clear ped_req got=%0b exp=0", ped_req);
    end
    button = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_vec++;
      if (ped_req !== 1'b0) begin
        n_err++;
        $display("FAIL clear_wins ped_req k=%0d got=%0b exp=0", k, ped_req);
      end
    end
    traff_state = 3'b011;
    step(1);
    n_vec++;
    if (ped_req !== 1'b0) begin
      n_err++;
      $display("FAIL clear_consumed ped_req got=%0b exp=0", ped_req);
    end
    button = 1'b0;
    step(8);
    $display("ped_clear: served in 100, ped_req=%0b", ped_req);
  endtask

  task automatic test_async_reset;
    button = 1'b1;
    step(6);
    n_vec++;
    if (ped_req !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset ped_req got=%0b exp=1", ped_req);
    end
    button = 1'b0;
    step(5);
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({timer_30s, timer_3s, ped_req, sec_count} !== 9'd0) begin
      n_err++;
      $display("FAIL async_reset got=%b exp=%b", {timer_30s, timer_3s, ped_req, sec_count}, 9'd0);
    end
    step(2);
    reset = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step(1);
      check_timing("post_reset", k, 1'b1);
      n_vec++;
      if (ped_req !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset ped_req k=%0d got=%0b exp=0", k, ped_req);
      end
    end
    $display("async_reset: restart sec=%0d t3=%0b ped=%0b", sec_count, timer_3s, ped_req);
  endtask

  initial begin
    test_reset();
    test_long_timer();
    test_state_change();
    test_tick_collision();
    test_glitch(1);
    test_glitch(2);
    test_button_press();
    test_ped_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
